clkgen_multi: RTL and testbench

- Parametrised, fully synchronous N-channel clock generator running from the 50 MHz refclk.
- Each channel produces a divided clock, a one-cycle rising-edge enable pulse, and a programmable start-phase delay.
- Generalises our fixed single-output 5 MHz PLL wrapper: runtime-programmable ratios, per-channel phase, and a locked indication that covers reprogramming.
- Sits beside the PLL; downstream logic uses outclk_en as clock enables in the refclk domain.

---
 rtl/clkgen_pkg.sv | 22 ++
 rtl/clkgen_chan.sv | 87 ++++++++
 rtl/clkgen_multi.sv | 104 ++++++++++
 tb/tb_clkgen_multi.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/clkgen_pkg.sv
// Shared types and config clamping for the multi-channel clock generator.
package clkgen_pkg;

   typedef enum logic [1:0] {RESTART, SETTLE, LOCKED} gstate_t;
   typedef enum logic {DELAY, RUN} cstate_t;

   localparam int unsigned MIN_DIV = 2;

   typedef struct packed {
      logic [31:0] div;
      logic [31:0] phase;
   } clamp_t;

   // Phase is limited against the already-clamped divide so it never exceeds div-1.
   function automatic clamp_t clamp_cfg(input logic [31:0] div, input logic [31:0] phase);
      clamp_t r;
      r.div   = (div < MIN_DIV) ? 32'(MIN_DIV) : div;
      r.phase = (phase > (r.div - 32'd1)) ? (r.div - 32'd1) : phase;
      return r;
   endfunction

endpackage

// File: rtl/clkgen_chan.sv
// One divided-clock channel: start delay, then a free-running divide-by-div_reg counter.
//
// state | meaning
// DELAY | outclk held low, cnt counts up to phase_reg
// RUN   | cnt wraps 0..div_reg-1, outclk high while cnt < div_reg/2
module clkgen_chan
   import clkgen_pkg::*;
#(
   parameter int DIV_W       = 16,
   parameter int DEFAULT_DIV = 10
) (
   input  logic             refclk,
   input  logic             rst,
   input  logic             restart,
   input  logic             wr_en,
   input  logic [DIV_W-1:0] wr_div,
   input  logic [DIV_W-1:0] wr_phase,
   output logic             outclk,
   output logic             outclk_en,
   output logic             running
);

   cstate_t          st, st_nxt;
   logic [DIV_W-1:0] div_reg, phase_reg;
   logic [DIV_W-1:0] cnt, cnt_nxt;
   logic [DIV_W-1:0] half;
   logic             out_nxt, en_nxt;

   assign half    = div_reg >> 1;
   assign running = (st == RUN);

   always_comb begin
      st_nxt  = st;
      cnt_nxt = cnt;
      out_nxt = 1'b0;
      if (restart) begin
         st_nxt  = DELAY;
         cnt_nxt = '0;
      end else begin
         case (st)
            DELAY: begin
               if (cnt == phase_reg) begin
                  st_nxt  = RUN;
                  cnt_nxt = '0;
                  out_nxt = (half != '0);
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            RUN: begin
               cnt_nxt = (cnt == (div_reg - 1'b1)) ? '0 : cnt + 1'b1;
               out_nxt = (cnt_nxt < half);
            end
            default: begin
               st_nxt  = DELAY;
               cnt_nxt = '0;
            end
         endcase
      end
      en_nxt = out_nxt & ~outclk;
   end

   always_ff @(posedge refclk) begin
      if (!rst) begin
         div_reg   <= DIV_W'(DEFAULT_DIV);
         phase_reg <= '0;
         st        <= DELAY;
         cnt       <= '0;
         outclk    <= 1'b0;
         outclk_en <= 1'b0;
      end else if (wr_en) begin
         // Park immediately so cnt never runs against a smaller new divide.
         div_reg   <= wr_div;
         phase_reg <= wr_phase;
         st        <= DELAY;
         cnt       <= '0;
         outclk    <= 1'b0;
         outclk_en <= 1'b0;
      end else begin
         st        <= st_nxt;
         cnt       <= cnt_nxt;
         outclk    <= out_nxt;
         outclk_en <= en_nxt;
      end
   end

endmodule

// File: rtl/clkgen_multi.sv
// N-channel clock generator: global restart/settle/lock sequencing and config decode.
//
// state   | meaning
// RESTART | one cycle, all channels forced back to DELAY together
// SETTLE  | counting cycles with every channel in RUN
// LOCKED  | locked=1, cfg_ready=1, accepting config
module clkgen_multi
   import clkgen_pkg::*;
#(
   parameter int NUM_CLK     = 4,
   parameter int DIV_W       = 16,
   parameter int DEFAULT_DIV = 10,
   parameter int LOCK_CYCLES = 16,
   localparam int CHAN_W     = (NUM_CLK > 1) ? $clog2(NUM_CLK) : 1
) (
   input  logic               refclk,
   input  logic               rst,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [CHAN_W-1:0]  cfg_chan,
   input  logic [DIV_W-1:0]   cfg_div,
   input  logic [DIV_W-1:0]   cfg_phase,
   output logic [NUM_CLK-1:0] outclk,
   output logic [NUM_CLK-1:0] outclk_en,
   output logic               locked
);

   localparam int SET_W = $clog2(LOCK_CYCLES + 1);

   gstate_t            state, state_nxt;
   logic [SET_W-1:0]   settle_cnt, settle_nxt;
   logic [NUM_CLK-1:0] sel, running;
   logic               accept, chan_ok, cfg_wr, all_run;
   clamp_t             clamped;
   logic               unused_clamp_hi;

   assign clamped         = clamp_cfg(32'(cfg_div), 32'(cfg_phase));
   assign unused_clamp_hi = ^{clamped.div[31:DIV_W], clamped.phase[31:DIV_W]};

   assign accept  = cfg_valid & cfg_ready;
   assign chan_ok = |sel;
   assign cfg_wr  = accept & chan_ok;
   assign all_run = &running;

   for (genvar i = 0; i < NUM_CLK; i++) begin : g_chan
      assign sel[i] = (cfg_chan == CHAN_W'(i));

      clkgen_chan #(
         .DIV_W       (DIV_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_chan (
         .refclk    (refclk),
         .rst       (rst),
         .restart   (state == RESTART),
         .wr_en     (accept & sel[i]),
         .wr_div    (clamped.div[DIV_W-1:0]),
         .wr_phase  (clamped.phase[DIV_W-1:0]),
         .outclk    (outclk[i]),
         .outclk_en (outclk_en[i]),
         .running   (running[i])
      );
   end

   always_comb begin
      state_nxt  = state;
      settle_nxt = settle_cnt;
      case (state)
         RESTART: begin
            state_nxt  = SETTLE;
            settle_nxt = '0;
         end
         SETTLE: begin
            if (all_run) begin
               if (settle_cnt == SET_W'(LOCK_CYCLES - 1)) begin
                  state_nxt  = LOCKED;
                  settle_nxt = '0;
               end else begin
                  settle_nxt = settle_cnt + 1'b1;
               end
            end
         end
         LOCKED: begin
            // Out-of-range channel requests complete the handshake without restarting.
            if (cfg_wr) state_nxt = RESTART;
         end
         default: state_nxt = RESTART;
      endcase
   end

   always_ff @(posedge refclk) begin
      if (!rst) begin
         state      <= RESTART;
         settle_cnt <= '0;
         locked     <= 1'b0;
         cfg_ready  <= 1'b0;
      end else begin
         state      <= state_nxt;
         settle_cnt <= settle_nxt;
         locked     <= (state_nxt == LOCKED);
         cfg_ready  <= (state_nxt == LOCKED);
      end
   end

endmodule

// File: tb/tb_clkgen_multi.sv
// Directed bench for clkgen_multi; three channels so a 2-bit cfg_chan can carry an out-of-range index.
module tb_clkgen_multi;

   localparam int NC    = 3;
   localparam int DIV_W = 16;

   logic             refclk = 1'b0;
   logic             rst = 1'b0;
   logic             cfg_valid = 1'b0;
   logic             cfg_ready;
   logic [1:0]       cfg_chan = '0;
   logic [DIV_W-1:0] cfg_div = '0;
   logic [DIV_W-1:0] cfg_phase = '0;
   logic [NC-1:0]    outclk, outclk_en;
   logic             locked;

   int n_asserts = 0;
   int n_fail    = 0;
   int kk        = 0;
   int exp_div[NC];
   int exp_ph[NC];

   clkgen_multi #(
      .NUM_CLK     (NC),
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (10),
      .LOCK_CYCLES (16)
   ) dut (
      .refclk    (refclk),
      .rst       (rst),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_chan  (cfg_chan),
      .cfg_div   (cfg_div),
      .cfg_phase (cfg_phase),
      .outclk    (outclk),
      .outclk_en (outclk_en),
      .locked    (locked)
   );

   always #10 refclk = ~refclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_asserts++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge refclk);
      #1;
   endtask

   // kk counts cycles since RESTART (cycle 0); first rise at phase+2, lock at max phase + 18.
   task automatic run_cycles(input int n);
      int maxp, m;
      logic eo, ee;
      for (int i = 0; i < n; i++) begin
         step();
         kk++;
         maxp = 0;
         for (int c = 0; c < NC; c++) if (exp_ph[c] > maxp) maxp = exp_ph[c];
         for (int c = 0; c < NC; c++) begin
            if (kk < exp_ph[c] + 2) begin
               eo = 1'b0;
               ee = 1'b0;
            end else begin
               m  = (kk - exp_ph[c] - 2) % exp_div[c];
               eo = (m < exp_div[c] / 2);
               ee = (m == 0);
            end
            chk($sformatf("outclk[%0d] k=%0d", c, kk), 32'(outclk[c]), 32'(eo));
            chk($sformatf("outclk_en[%0d] k=%0d", c, kk), 32'(outclk_en[c]), 32'(ee));
         end
         chk($sformatf("locked k=%0d", kk), 32'(locked), 32'(kk >= maxp + 18));
         chk($sformatf("cfg_ready k=%0d", kk), 32'(cfg_ready), 32'(kk >= maxp + 18));
      end
   endtask

   task automatic accept_restart(input string tag);
      step();
      kk = 0;
      chk({tag, " locked drop"}, 32'(locked), 32'd0);
      chk({tag, " ready drop"}, 32'(cfg_ready), 32'd0);
   endtask

   task automatic set_cfg(input int ch, input int dv, input int ph);
      cfg_valid = 1'b1;
      cfg_chan  = 2'(ch);
      cfg_div   = DIV_W'(dv);
      cfg_phase = DIV_W'(ph);
   endtask

   initial begin
      for (int c = 0; c < NC; c++) begin
         exp_div[c] = 10;
         exp_ph[c]  = 0;
      end

      // Reset and default bring-up: period 10, rise at cycle 2, lock at 18.
      step();
      step();
      chk("reset outclk", 32'(outclk), 32'd0);
      chk("reset outclk_en", 32'(outclk_en), 32'd0);
      chk("reset locked", 32'(locked), 32'd0);
      chk("reset cfg_ready", 32'(cfg_ready), 32'd0);
      rst = 1'b1;
      kk  = 0;
      run_cycles(40);

      // ch1 div 7 phase 3.
      set_cfg(1, 7, 3);
      accept_restart("ch1 d7p3");
      cfg_valid = 1'b0;
      exp_div[1] = 7;
      exp_ph[1]  = 3;
      run_cycles(45);

      // ch2 div 0 clamps to 2.
      set_cfg(2, 0, 0);
      accept_restart("ch2 d0");
      cfg_valid = 1'b0;
      exp_div[2] = 2;
      exp_ph[2]  = 0;
      run_cycles(30);

      // ch2 div 1 clamps to 2, phase 5 clamps to 1.
      set_cfg(2, 1, 5);
      accept_restart("ch2 d1");
      cfg_valid = 1'b0;
      exp_ph[2] = 1;
      run_cycles(30);

      // ch0 div 4 phase 9 clamps phase to 3.
      set_cfg(0, 4, 9);
      accept_restart("ch0 d4p9");
      cfg_valid = 1'b0;
      exp_div[0] = 4;
      exp_ph[0]  = 3;
      run_cycles(35);

      // Out-of-range channel: accepted, discarded, no restart.
      set_cfg(3, 3, 0);
      run_cycles(1);
      cfg_valid = 1'b0;
      run_cycles(20);

      // Reprogram, then pulse reset mid-SETTLE.
      set_cfg(1, 5, 2);
      accept_restart("ch1 d5p2");
      cfg_valid = 1'b0;
      exp_div[1] = 5;
      exp_ph[1]  = 2;
      run_cycles(8);
      rst = 1'b0;
      step();
      rst = 1'b1;
      chk("midsettle rst outclk", 32'(outclk), 32'd0);
      chk("midsettle rst outclk_en", 32'(outclk_en), 32'd0);
      chk("midsettle rst locked", 32'(locked), 32'd0);
      kk = 0;
      for (int c = 0; c < NC; c++) begin
         exp_div[c] = 10;
         exp_ph[c]  = 0;
      end
      run_cycles(5);

      // Request held during SETTLE is only taken once locked.
      set_cfg(0, 6, 1);
      run_cycles(13);
      accept_restart("held req");
      cfg_valid = 1'b0;
      exp_div[0] = 6;
      exp_ph[0]  = 1;
      run_cycles(30);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
